ex_mem: RTL and testbench

EX_MEM -- requirements
Module: ex_mem

---
 rtl/ex_mem.sv | 138 +++++++++++++
 tb/tb_ex_mem.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register.
//
// Carries the EX write-back and HI/LO fields into MEM. It also returns the
// madd/msub partial product and step count to EX while EX is stalled. Every
// output is a flop, so there is no combinational path from input to output.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; clears every output
//   stall[5:0] pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled
//   flush      clears every output on the next edge, whatever stall is
//   ex_*       write-back and HI/LO fields from EX
//   hilo_i     madd/msub partial product from EX
//   cnt_i      madd/msub step count from EX
//   mem_*      registered write-back and HI/LO fields to MEM
//   hilo_o     partial product returned to EX
//   cnt_o      step count returned to EX
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,

    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,

    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    logic [4:0]  mem_wd_d,    mem_wd_q;
    logic        mem_wreg_d,  mem_wreg_q;
    logic [31:0] mem_wdata_d, mem_wdata_q;
    logic [31:0] mem_hi_d,    mem_hi_q;
    logic [31:0] mem_lo_d,    mem_lo_q;
    logic        mem_whilo_d, mem_whilo_q;
    logic [63:0] hilo_d,      hilo_q;
    logic [1:0]  cnt_d,       cnt_q;

    // Only the EX and MEM stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        mem_hi_d    = mem_hi_q;
        mem_lo_d    = mem_lo_q;
        mem_whilo_d = mem_whilo_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;

        if (rst || flush) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
            mem_hi_d    = '0;
            mem_lo_d    = '0;
            mem_whilo_d = 1'b0;
            hilo_d      = '0;
            cnt_d       = '0;
        end else begin
            case ({stall[4], stall[3]})
                2'b00: begin
                    // Advance: pass EX forward and end any accumulation.
                    mem_wd_d    = ex_wd;
                    mem_wreg_d  = ex_wreg;
                    mem_wdata_d = ex_wdata;
                    mem_hi_d    = ex_hi;
                    mem_lo_d    = ex_lo;
                    mem_whilo_d = ex_whilo;
                    hilo_d      = '0;
                    cnt_d       = '0;
                end
                2'b01: begin
                    // Bubble: send a NOP to MEM, keep accumulating.
                    mem_wd_d    = '0;
                    mem_wreg_d  = 1'b0;
                    mem_wdata_d = '0;
                    mem_hi_d    = '0;
                    mem_lo_d    = '0;
                    mem_whilo_d = 1'b0;
                    hilo_d      = hilo_i;
                    cnt_d       = cnt_i;
                end
                2'b11: begin
                    // Hold: MEM fields keep their values, keep accumulating.
                    hilo_d = hilo_i;
                    cnt_d  = cnt_i;
                end
                default: begin
                    // MEM stalled while EX advances: hold MEM, drop accumulation.
                    hilo_d = '0;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_wd_q    <= mem_wd_d;
        mem_wreg_q  <= mem_wreg_d;
        mem_wdata_q <= mem_wdata_d;
        mem_hi_q    <= mem_hi_d;
        mem_lo_q    <= mem_lo_d;
        mem_whilo_q <= mem_whilo_d;
        hilo_q      <= hilo_d;
        cnt_q       <= cnt_d;
    end

    assign mem_wd    = mem_wd_q;
    assign mem_wreg  = mem_wreg_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_hi    = mem_hi_q;
    assign mem_lo    = mem_lo_q;
    assign mem_whilo = mem_whilo_q;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

    // MEM can never be stalled while EX advances; flag it when it happens.
    illegal_stall_a : assert property (
        @(posedge clk) disable iff (rst || flush) !(stall[4] && !stall[3])
    ) else $warning("ex_mem: illegal stall combination, MEM stalled while EX advances");

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    ex_mem dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .ex_whilo  (ex_whilo),
        .hilo_i    (hilo_i),
        .cnt_i     (cnt_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .mem_whilo (mem_whilo),
        .hilo_o    (hilo_o),
        .cnt_o     (cnt_o)
    );

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } outs_t;

    outs_t exp_q[$];
    string name_q[$];
    outs_t exp_v;
    outs_t mon_exp;
    outs_t mon_act;
    string mon_name;
    int    errors = 0;
    int    checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected record per edge, compared just after that edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s: got wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h",
                         mon_name, mon_act.wd, mon_act.wreg, mon_act.wdata, mon_act.hi,
                         mon_act.lo, mon_act.whilo, mon_act.hilo, mon_act.cnt);
                $display("     %s: want wd=%h wreg=%b wdata=%h hi=%h lo=%h whilo=%b hilo=%h cnt=%h",
                         mon_name, mon_exp.wd, mon_exp.wreg, mon_exp.wdata, mon_exp.hi,
                         mon_exp.lo, mon_exp.whilo, mon_exp.hilo, mon_exp.cnt);
            end
        end
    end

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                          input logic [63:0] hilo, input logic [1:0] cnt);
        ex_wd    = wd;
        ex_wreg  = wreg;
        ex_wdata = wdata;
        ex_hi    = hi;
        ex_lo    = lo;
        ex_whilo = whilo;
        hilo_i   = hilo;
        cnt_i    = cnt;
    endtask

    task automatic set_exp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                           input logic [63:0] hilo, input logic [1:0] cnt);
        exp_v = {wd, wreg, wdata, hi, lo, whilo, hilo, cnt};
    endtask

    // Inputs are driven at the falling edge; the expectation is for the next rising edge.
    task automatic cyc(input string n);
        exp_q.push_back(exp_v);
        name_q.push_back(n);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        stall = 6'b000000;
        set_ex(5'd7, 1'b1, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 1'b1,
               64'hFFFF_0000_FFFF_0000, 2'd3);
        @(negedge clk);

        // Reset for two cycles with busy EX inputs.
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset_1");
        cyc("reset_2");

        rst = 1'b0;
        set_ex(5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 64'h0000_0000_0000_ABCD, 2'd2);
        set_exp(5'd5, 1'b1, 32'h1234_5678, 0, 0, 0, 0, 0);
        cyc("advance_after_reset");

        stall = 6'b001111;
        set_ex(5'd9, 1'b1, 32'hDEAD_BEEF, 32'h3, 32'h4, 1'b1, 64'h0000_0001_0000_0002, 2'd1);
        set_exp(0, 0, 0, 0, 0, 0, 64'h0000_0001_0000_0002, 2'd1);
        cyc("bubble");

        stall = 6'b000000;
        set_ex(5'd3, 1'b1, 32'hA5A5_A5A5, 32'h11, 32'h22, 1'b1, 64'h0, 2'd0);
        set_exp(5'd3, 1'b1, 32'hA5A5_A5A5, 32'h11, 32'h22, 1'b1, 0, 0);
        cyc("load_a5");

        stall = 6'b011111;
        for (int i = 1; i <= 3; i++) begin
            set_ex(5'(i + 10), 1'b0, 32'(i), 32'(i * 7), 32'(i * 9), 1'b0,
                   64'(i * 16), 2'(i));
            set_exp(5'd3, 1'b1, 32'hA5A5_A5A5, 32'h11, 32'h22, 1'b1, 64'(i * 16), 2'(i));
            cyc($sformatf("hold_%0d", i));
        end

        // MEM stalled while EX advances: MEM held, accumulator dropped.
        stall = 6'b010000;
        set_ex(5'd20, 1'b1, 32'h77, 32'h8, 32'h9, 1'b1, 64'h55, 2'd2);
        set_exp(5'd3, 1'b1, 32'hA5A5_A5A5, 32'h11, 32'h22, 1'b1, 0, 0);
        cyc("illegal_stall");

        // Two-step madd under bubble, then completion.
        stall = 6'b001111;
        set_ex(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h100, 2'd1);
        set_exp(0, 0, 0, 0, 0, 0, 64'h100, 2'd1);
        cyc("madd_step1");

        set_ex(5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 64'h200, 2'd2);
        set_exp(0, 0, 0, 0, 0, 0, 64'h200, 2'd2);
        cyc("madd_step2");

        stall = 6'b000000;
        set_ex(5'd0, 1'b0, 32'h0, 32'h1, 32'h2, 1'b1, 64'h300, 2'd3);
        set_exp(0, 0, 0, 32'h1, 32'h2, 1'b1, 0, 0);
        cyc("madd_complete");

        // Build cnt_o=1 under hold, then flush against the stall.
        stall = 6'b011111;
        set_ex(5'd6, 1'b1, 32'h66, 32'h0, 32'h0, 1'b0, 64'h300, 2'd1);
        set_exp(0, 0, 0, 32'h1, 32'h2, 1'b1, 64'h300, 2'd1);
        cyc("hold_cnt1");

        flush = 1'b1;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("flush_vs_stall");

        flush = 1'b0;
        stall = 6'b000000;
        set_ex(5'd4, 1'b1, 32'h99, 32'h5, 32'h6, 1'b1, 64'h1, 2'd1);
        set_exp(5'd4, 1'b1, 32'h99, 32'h5, 32'h6, 1'b1, 0, 0);
        cyc("advance_after_flush");

        rst   = 1'b1;
        flush = 1'b1;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset_with_flush");

        rst   = 1'b0;
        flush = 1'b0;
        set_ex(5'd31, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 64'h7, 2'd3);
        set_exp(5'd31, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 0, 0);
        cyc("advance_full_width");

        // Let the monitor drain, bounded.
        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
